// File: rtl/seq_scan_ctrl.sv
`timescale 1ns/1ps
// seq_scan_ctrl: loads an N-bit word on a start handshake, clears the attached
// serial sequence detector, shifts the word into it MSB-first and tallies the
// detector hits. It also records the bit index of the first hit.
module seq_scan_ctrl #(
    parameter int N   = 32,
    parameter int LAT = 0,
    parameter int CW  = 6,
    parameter int PW  = 5
) (
    input  logic          ck,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  data,
    input  logic          abort,
    input  logic          z,
    output logic          x,
    output logic          det_clr,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic          found,
    output logic [PW-1:0] first_pos
);

    // The hit pipe needs at least one stage to stay legal when LAT is 0.
    localparam int PD = (LAT > 0) ? LAT : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        sreg_q, sreg_d;
    logic [PW-1:0]       bitcnt_q, bitcnt_d;
    logic [1:0]          drain_q, drain_d;
    logic [CW-1:0]       count_q, count_d;
    logic                found_q, found_d;
    logic [PW-1:0]       first_pos_q, first_pos_d;
    logic [PD-1:0]       pv_q, pv_d;
    logic [PD-1:0][PW-1:0] pi_q, pi_d;

    logic                abort_active;
    logic                hit_valid;
    logic [PW-1:0]       hit_idx;
    logic                hit;

    // An abort only matters while a scan is actually running.
    assign abort_active = abort &&
                          ((state_q == S_CLEAR) || (state_q == S_SHIFT) || (state_q == S_DRAIN));

    // A Mealy detector answers in the same cycle; otherwise use the delayed tag.
    assign hit_valid = (LAT == 0) ? (state_q == S_SHIFT) : pv_q[PD-1];
    assign hit_idx   = (LAT == 0) ? bitcnt_q : pi_q[PD-1];
    assign hit       = hit_valid && z && !abort_active;

    // Outputs are pure decodes of registered state so the detector sees clean levels.
    assign x         = (state_q == S_SHIFT) && sreg_q[N-1];
    assign det_clr   = (state_q == S_CLEAR);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign count     = count_q;
    assign found     = found_q;
    assign first_pos = first_pos_q;

    // Tag pipe: carries the bit index alongside its valid flag until the detector answers.
    always_comb begin
        pv_d = pv_q;
        pi_d = pi_q;
        pv_d[0] = (state_q == S_SHIFT);
        pi_d[0] = bitcnt_q;
        for (int i = 1; i < PD; i++) begin
            pv_d[i] = pv_q[i-1];
            pi_d[i] = pi_q[i-1];
        end
        if (abort_active || (LAT == 0)) begin
            pv_d = '0;
            pi_d = '0;
        end
    end

    // Next-state logic for the sequencer together with hit accounting.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bitcnt_d    = bitcnt_q;
        drain_d     = drain_q;
        count_d     = count_q;
        found_d     = found_q;
        first_pos_d = first_pos_q;

        if (hit) begin
            if (count_q != '1) begin
                count_d = count_q + CW'(1);
            end
            if (!found_q) begin
                found_d     = 1'b1;
                first_pos_d = hit_idx;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_CLEAR;
                    sreg_d      = data;
                    bitcnt_d    = '0;
                    count_d     = '0;
                    found_d     = 1'b0;
                    first_pos_d = '1;
                end
            end
            S_CLEAR: begin
                state_d  = S_SHIFT;
                bitcnt_d = '0;
            end
            S_SHIFT: begin
                sreg_d   = sreg_q << 1;
                bitcnt_d = bitcnt_q + PW'(1);
                if (bitcnt_q == PW'(N - 1)) begin
                    drain_d = '0;
                    state_d = (LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'(LAT - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_active) begin
            state_d = S_IDLE;
        end
    end

    // State and result registers, forced to idle values as soon as reset drops.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sreg_q      <= '0;
            bitcnt_q    <= '0;
            drain_q     <= '0;
            count_q     <= '0;
            found_q     <= 1'b0;
            first_pos_q <= '1;
            pv_q        <= '0;
            pi_q        <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bitcnt_q    <= bitcnt_d;
            drain_q     <= drain_d;
            count_q     <= count_d;
            found_q     <= found_d;
            first_pos_q <= first_pos_d;
            pv_q        <= pv_d;
            pi_q        <= pi_d;
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for seq_scan_ctrl: a Mealy instance (LAT=0, CW=6) and a Moore instance
// (LAT=1, CW=4) run side by side, each driving its own behavioural detector.
module tb_seq_scan_ctrl;

    localparam int N = 32;

    logic        ck = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic        abort;
    logic [31:0] data;

    logic        x0, clr0, busy0, done0, found0, z0;
    logic [5:0]  cnt0;
    logic [4:0]  fp0;
    logic        x1, clr1, busy1, done1, found1;
    logic        z1 = 1'b0;
    logic [3:0]  cnt1;
    logic [4:0]  fp1;

    int errors = 0;
    int checks = 0;
    int ec[2];
    int ef[2];
    int ep[2];

    // Free-running clock.
    always #5 ck = ~ck;

    // Mealy detector: a hit for every '1' presented on x.
    assign z0 = x0;

    // Moore detector: the same rule, answered one clock later.
    always @(posedge ck) begin
        if (clr1) z1 <= 1'b0;
        else      z1 <= x1;
    end

    seq_scan_ctrl #(.N(N), .LAT(0), .CW(6), .PW(5)) dut0 (
        .ck(ck), .reset(reset), .start(start0), .data(data), .abort(abort), .z(z0),
        .x(x0), .det_clr(clr0), .busy(busy0), .done(done0),
        .count(cnt0), .found(found0), .first_pos(fp0)
    );

    seq_scan_ctrl #(.N(N), .LAT(1), .CW(4), .PW(5)) dut1 (
        .ck(ck), .reset(reset), .start(start1), .data(data), .abort(abort), .z(z1),
        .x(x1), .det_clr(clr1), .busy(busy1), .done(done1),
        .count(cnt1), .found(found1), .first_pos(fp1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResults(input string when);
        checkOutput({when, " dut0 count"}, 32'(cnt0), ec[0]);
        checkOutput({when, " dut0 found"}, 32'(found0), ef[0]);
        checkOutput({when, " dut0 first_pos"}, 32'(fp0), ep[0]);
        checkOutput({when, " dut1 count"}, 32'(cnt1), ec[1]);
        checkOutput({when, " dut1 found"}, 32'(found1), ef[1]);
        checkOutput({when, " dut1 first_pos"}, 32'(fp1), ep[1]);
    endtask

    // Expected outcome of a scan: every '1' whose detector answer lands before any abort is a hit.
    task automatic modelScan(input logic [31:0] d, input int abort_cyc);
        for (int j = 0; j < 2; j++) begin
            int kmax;
            int hits;
            int cap;
            kmax = (abort_cyc > 0) ? abort_cyc - 3 - j : N - 1;
            cap  = (j == 0) ? 63 : 15;
            hits = 0;
            ef[j] = 0;
            ep[j] = 31;
            for (int i = 0; i < N; i++) begin
                if (i <= kmax && d[N-1-i]) begin
                    if (ef[j] == 0) ep[j] = i;
                    ef[j] = 1;
                    hits++;
                end
            end
            ec[j] = (hits > cap) ? cap : hits;
        end
    endtask

    task automatic clearExpected();
        for (int j = 0; j < 2; j++) begin
            ec[j] = 0;
            ef[j] = 0;
            ep[j] = 31;
        end
    endtask

    // Expected handshake/serial outputs for cycle c after the accepting edge.
    task automatic checkCycle(input int c, input int abort_cyc, input logic [31:0] d);
        for (int j = 0; j < 2; j++) begin
            int   dc;
            int   last;
            logic ex;
            logic ox, oc, ob, od;
            dc   = N + 2 + j;
            last = (abort_cyc > 0) ? abort_cyc : dc;
            ex   = (c >= 2 && c <= N + 1 && c <= last) ? d[N+1-c] : 1'b0;
            ox = (j == 0) ? x0    : x1;
            oc = (j == 0) ? clr0  : clr1;
            ob = (j == 0) ? busy0 : busy1;
            od = (j == 0) ? done0 : done1;
            checkOutput($sformatf("dut%0d x c%0d", j, c), 32'(ox), 32'(ex));
            checkOutput($sformatf("dut%0d det_clr c%0d", j, c), 32'(oc), 32'(c == 1));
            checkOutput($sformatf("dut%0d busy c%0d", j, c), 32'(ob), 32'(c <= last));
            checkOutput($sformatf("dut%0d done c%0d", j, c), 32'(od), 32'(abort_cyc == 0 && c == dc));
        end
    endtask

    // One scan: present the word, pulse (or hold) start, then follow every cycle to idle.
    task automatic applyStimulus(input logic [31:0] d, input int abort_cyc, input bit keep_start);
        int lastmax;
        data   = d;
        start0 = 1'b1;
        start1 = 1'b1;
        @(posedge ck);
        #1;
        start0 = keep_start;
        start1 = keep_start;
        data   = $urandom();
        lastmax = (abort_cyc > 0) ? abort_cyc : N + 3;
        for (int c = 1; c <= lastmax + 1; c++) begin
            @(negedge ck);
            checkCycle(c, abort_cyc, d);
            if (c == 1) begin
                clearExpected();
                checkResults("scan start");
            end
            if (c == lastmax + 1) begin
                modelScan(d, abort_cyc);
                checkResults("scan end");
            end else begin
                if (c == abort_cyc) abort = 1'b1;
                @(posedge ck);
                #1;
                abort  = 1'b0;
                start0 = keep_start && (c + 1 <= N + 2);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ck);
            #1;
            checkOutput("idle dut0 busy", 32'(busy0), 32'd0);
            checkOutput("idle dut1 busy", 32'(busy1), 32'd0);
            checkResults("idle hold");
        end
    endtask

    task automatic checkResetOutputs(input string when);
        checkOutput({when, " dut0 x"}, 32'(x0), 32'd0);
        checkOutput({when, " dut0 det_clr"}, 32'(clr0), 32'd0);
        checkOutput({when, " dut0 busy"}, 32'(busy0), 32'd0);
        checkOutput({when, " dut0 done"}, 32'(done0), 32'd0);
        checkOutput({when, " dut1 x"}, 32'(x1), 32'd0);
        checkOutput({when, " dut1 det_clr"}, 32'(clr1), 32'd0);
        checkOutput({when, " dut1 busy"}, 32'(busy1), 32'd0);
        checkOutput({when, " dut1 done"}, 32'(done1), 32'd0);
        clearExpected();
        checkResults(when);
    endtask

    initial begin
        reset  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        abort  = 1'b0;
        data   = '0;
        #12;
        checkResetOutputs("power-on reset");
        @(negedge ck);
        reset = 1'b1;
        @(posedge ck);
        #1;

        $display("[TB] all-zero word");
        applyStimulus(32'h0000_0000, 0, 1'b0);

        $display("[TB] reference word on Mealy and Moore instances");
        applyStimulus(32'h270E_9253, 0, 1'b0);

        $display("[TB] all-ones word with start held through DONE");
        applyStimulus(32'hFFFF_FFFF, 0, 1'b1);

        $display("[TB] second scan aborted in cycle 10");
        applyStimulus(32'h270E_9253, 10, 1'b0);
        idleCycles(3);

        $display("[TB] asynchronous reset in the middle of a shift");
        data   = $urandom() | 32'hF000_0000;
        start0 = 1'b1;
        start1 = 1'b1;
        @(posedge ck);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (12) @(posedge ck);
        #3;
        checkOutput("pre-reset dut0 busy", 32'(busy0), 32'd1);
        reset = 1'b0;
        #1;
        checkResetOutputs("mid-scan reset");
        @(negedge ck);
        reset = 1'b1;
        applyStimulus($urandom(), 0, 1'b0);

        $display("[TB] randomized scans");
        for (int s = 0; s < 8; s++) begin
            logic [31:0] d;
            int          a;
            d = $urandom();
            a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N + 1)) : 0;
            applyStimulus(d, a, 1'b0);
            idleCycles(1);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
